fpu_flaggen: RTL and testbench
==============================

Name: fpu_flaggen

Overview:
Iterative single-precision FP add/sub/compare unit that produces the FPUFlags/FPUFlagW pair consumed by the condition logic. It is the producer side of the FPU flag interface. It sits in the datapath beside the ALU and is started by the controller with a start/busy/done handshake. Results and NZCV flags are valid for exactly one cycle with done; the datapath writes result and the flag logic latches the flags on that cycle.

Parameters:
MAX_ALIGN, 26, exponent difference at or above which the smaller operand is treated as zero (sticky only).

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  launch operation; ignored while busy=1
op  input  2  00 FADD, 01 FSUB, 10 FCMP, 11 reserved (treated as FCMP)
sflag  input  1  instruction S bit; gates FPUFlagW for FADD/FSUB
a  input  32  operand A, IEEE-754 single
b  input  32  operand B
busy  output  1  operation in progress
done  output  1  one-cycle pulse; result, FPUFlags and FPUFlagW valid
result  output  32  sum/difference; 0 for FCMP
FPUFlags  output  4  {N,Z,C,V}
FPUFlagW  output  2  [1] enables NZ write, [0] enables CV write; nonzero only while done=1

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; busy, done, result, FPUFlags and FPUFlagW all 0. Reset mid-operation aborts with no done pulse.
- Capture: a, b, op and sflag are registered on the cycle start=1 with state IDLE; busy rises the next cycle.
- Inputs: denormals are flushed to ±0. Classes are zero, normal, inf and NaN.
- FSM:
  - IDLE -> UNPACK.
  - UNPACK -> CMP (FCMP), SPECIAL (any NaN/inf/zero shortcut), or ALIGN.
  - ALIGN: shifts the smaller mantissa right 1 bit per cycle, OR-ing shifted-out bits into sticky, until the exponents are equal. If the difference is >= MAX_ALIGN, it skips directly with mantissa=0 and sticky=1.
  - ADD: 27-bit signed magnitude add/sub (hidden bit + 23 + guard/round/sticky).
  - NORM: a carry-out shifts right once; otherwise shifts left 1 bit per cycle until bit 26 is set or the exponent reaches 1 (then flush to zero).
  - ROUND -> DONE -> IDLE.
- Latency: FCMP and SPECIAL are done on the 3rd cycle after start. Add/sub worst case is under 60 cycles.
- Rounding: truncation toward zero (see optional feature).
- FCMP flags (ARM VCMP encoding): equal 0110, less 1000, greater 0010, unordered (any NaN) 0011. +0 and -0 compare equal. FPUFlagW=11 always. result=0.
- FADD/FSUB flags:
  - N is the result sign.
  - Z=1 when the result is ±0.
  - C=0.
  - V=1 on overflow to inf, or when the result is NaN.
  - FPUFlagW = sflag ? 11 : 00.
- Specials:
  - Any NaN, or inf-inf, gives 0x7FC00000.
  - inf±finite gives inf.
  - An exact-zero sum is +0.
  - Exponent overflow (>=255) gives ±inf with V=1.
- Outputs (result, FPUFlags, FPUFlagW) are registered. They hold their values after done falls, but FPUFlagW returns to 00.
- A start on the same cycle as done (state DONE) is ignored; the controller must wait for IDLE.

Optional Feature:
FPU_RNE_EN
- Defined: ROUND applies round-to-nearest-even using guard/round/sticky; mantissa overflow from rounding re-increments the exponent (which may overflow to inf with V=1). Adds 1 cycle only when rounding carries out.
- Undefined: ROUND truncates; the state is a single pass-through cycle.

Decomposition:
- Package fpu_pkg:
  - op codes FOP_ADD/FOP_SUB/FOP_CMP;
  - state enum;
  - class enum (CLS_ZERO/NORM/INF/NAN);
  - constants QNAN=32'h7FC00000, EXP_MAX=8'hFF;
  - flag encodings CMP_EQ/LT/GT/UN.
- One sub-module: fpu_classify. It is combinational, instantiated twice. It maps a 32-bit operand to {sign, exp, 24-bit mantissa with hidden bit, class} with denormal flush.

Test Plan:
- FCMP a=0x3F800000, b=0x40000000 -> done on 3rd cycle after start, FPUFlags=1000, FPUFlagW=11, result=0.
- FADD 0x3F800000+0x3F800000, sflag=1 -> result 0x40000000, FPUFlags=0000, FPUFlagW=11; same with sflag=0 -> FPUFlagW=00.
- FSUB 0x3F800000-0x3F800000, sflag=1 -> result 0x00000000, FPUFlags=0100.
- FADD 0x7F7FFFFF+0x7F7FFFFF -> result 0x7F800000, FPUFlags=0001; FCMP 0x7FC00000 vs 0x3F800000 -> FPUFlags=0011.
- FADD 0x3F800000+0x33C00000 -> 0x3F800000 without FPU_RNE_EN, 0x3F800001 with it.
- FADD 0x3F800000+0x35800000, drive reset=0 during ALIGN -> busy, done and FPUFlagW are 0 immediately; the next FADD 1.0+1.0 returns 0x40000000. start pulses while busy are ignored (no extra done).

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and constants for the iterative FP add/sub/compare
// flag producer (fpu_flaggen) and its operand classifier (fpu_classify).
//   - op codes, FSM state enum, operand class enum
//   - unpacked-operand struct carried from classifier to datapath
//   - NZCV encodings for compare, helper to derive add/sub NZCV
package fpu_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 24;   // hidden bit + 23 fraction bits
  localparam int unsigned WORK_W = 27;   // mantissa + guard/round/sticky
  localparam int unsigned SUM_W  = 28;   // working width plus carry-out

  localparam logic [1:0] FOP_ADD = 2'b00;
  localparam logic [1:0] FOP_SUB = 2'b01;
  localparam logic [1:0] FOP_CMP = 2'b10;
  localparam logic [1:0] FOP_RSV = 2'b11;

  localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  // {N,Z,C,V} for compare outcomes
  localparam logic [3:0] CMP_EQ = 4'b0110;
  localparam logic [3:0] CMP_LT = 4'b1000;
  localparam logic [3:0] CMP_GT = 4'b0010;
  localparam logic [3:0] CMP_UN = 4'b0011;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_CMP,
    ST_SPECIAL,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } fsm_state_e;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_cls_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    fp_cls_e           cls;
  } fp_unpk_t;

  // NZCV for an add/sub result word: C is always clear, V on overflow or NaN
  function automatic logic [3:0] add_nzcv(input logic [31:0] res, input logic ovf);
    logic is_nan;
    is_nan = (res[30:23] == EXP_MAX) && (res[22:0] != 23'd0);
    return {res[31], ~|res[30:0], 1'b0, ovf | is_nan};
  endfunction

endpackage

// File: rtl/fpu_classify.sv
// fpu_classify: combinational unpack of an IEEE-754 single into sign,
// exponent, mantissa-with-hidden-bit and class. Denormals flush to signed zero.
//   i_op      : 32-bit operand
//   o_unpk_c  : unpacked operand (fp_unpk_t)
module fpu_classify
  import fpu_pkg::*;
(
  input  logic [31:0] i_op,
  output fp_unpk_t    o_unpk_c
);

  always_comb begin
    o_unpk_c.sign = i_op[31];
    o_unpk_c.exp  = i_op[30:23];
    o_unpk_c.mant = {1'b1, i_op[22:0]};
    o_unpk_c.cls  = CLS_NORM;
    if (i_op[30:23] == 8'd0) begin
      // zero and denormal both collapse to an all-zero magnitude
      o_unpk_c.exp  = 8'd0;
      o_unpk_c.mant = 24'd0;
      o_unpk_c.cls  = CLS_ZERO;
    end else if (i_op[30:23] == EXP_MAX) begin
      o_unpk_c.mant = {1'b0, i_op[22:0]};
      o_unpk_c.cls  = (i_op[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
    end
  end

endmodule

// File: rtl/fpu_flaggen.sv
// fpu_flaggen: iterative single-precision add/sub/compare producing the
// FPUFlags/FPUFlagW pair for the condition logic.
// Optional macro FPU_RNE_EN: round-to-nearest-even in ROUND (default truncate).
//   clk, reset     : clock, asynchronous active-low reset
//   start          : launch (accepted only in IDLE)
//   op             : 00 FADD, 01 FSUB, 10/11 FCMP
//   sflag          : enables FPUFlagW for FADD/FSUB
//   a, b           : IEEE-754 single operands
//   busy           : operation in progress
//   done           : one-cycle pulse, result/FPUFlags/FPUFlagW valid
//   result         : sum/difference, 0 for FCMP
//   FPUFlags       : {N,Z,C,V}
//   FPUFlagW       : [1] NZ write enable, [0] CV write enable (only with done)
module fpu_flaggen
  import fpu_pkg::*;
#(
  parameter int unsigned MAX_ALIGN = 26
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic        sflag,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [3:0]  FPUFlags,
  output logic [1:0]  FPUFlagW
);

  localparam logic [EXP_W-1:0] ALIGN_LIM = EXP_W'(MAX_ALIGN);

  fsm_state_e        r_state;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic [1:0]        r_op;
  logic              r_sflag;
  logic [EXP_W-1:0]  r_ex;
  logic [EXP_W-1:0]  r_diff;
  logic [WORK_W-1:0] r_mx;
  logic [WORK_W-1:0] r_my;
  logic              r_sx;
  logic              r_sy;
  logic [SUM_W-1:0]  r_sum;
  logic              r_rs;
  logic [9:0]        r_exp;

  fp_unpk_t          w_ua;
  fp_unpk_t          w_ub;
  logic              w_sb_eff;
  logic              w_is_cmp;
  logic              w_any_spec;
  logic [31:0]       w_spec_res;
  logic [3:0]        w_cmp_flags;
  logic [SUM_W-1:0]  w_add_sum;
  logic              w_add_sign;
  logic [31:0]       w_pack;
  logic              w_ovf;
  logic              w_round_again;

  fpu_classify u_cls_a (.i_op(r_a), .o_unpk_c(w_ua));
  fpu_classify u_cls_b (.i_op(r_b), .o_unpk_c(w_ub));

  // Operation decode; FSUB is an add with B's sign flipped
  always_comb begin
    w_is_cmp   = (r_op == FOP_CMP) || (r_op == FOP_RSV);
    w_sb_eff   = w_ub.sign ^ (r_op == FOP_SUB);
    w_any_spec = (w_ua.cls != CLS_NORM) || (w_ub.cls != CLS_NORM);
  end

  // Shortcut results when either operand is zero, inf or NaN
  always_comb begin
    w_spec_res = {w_ua.sign, w_ua.exp, w_ua.mant[22:0]};
    if ((w_ua.cls == CLS_NAN) || (w_ub.cls == CLS_NAN)) begin
      w_spec_res = QNAN;
    end else if ((w_ua.cls == CLS_INF) && (w_ub.cls == CLS_INF)) begin
      w_spec_res = (w_ua.sign != w_sb_eff) ? QNAN : {w_ua.sign, EXP_MAX, 23'd0};
    end else if (w_ua.cls == CLS_INF) begin
      w_spec_res = {w_ua.sign, EXP_MAX, 23'd0};
    end else if (w_ub.cls == CLS_INF) begin
      w_spec_res = {w_sb_eff, EXP_MAX, 23'd0};
    end else if ((w_ua.cls == CLS_ZERO) && (w_ub.cls == CLS_ZERO)) begin
      w_spec_res = 32'd0;
    end else if (w_ua.cls == CLS_ZERO) begin
      w_spec_res = {w_sb_eff, w_ub.exp, w_ub.mant[22:0]};
    end
  end

  // Compare: sign/magnitude ordering on flushed operands, +0 == -0
  always_comb begin
    logic [30:0] mag_a;
    logic [30:0] mag_b;
    mag_a       = {w_ua.exp, w_ua.mant[22:0]};
    mag_b       = {w_ub.exp, w_ub.mant[22:0]};
    w_cmp_flags = CMP_GT;
    if ((w_ua.cls == CLS_NAN) || (w_ub.cls == CLS_NAN)) begin
      w_cmp_flags = CMP_UN;
    end else if ((mag_a == 31'd0) && (mag_b == 31'd0)) begin
      w_cmp_flags = CMP_EQ;
    end else if (w_ua.sign != w_ub.sign) begin
      w_cmp_flags = w_ua.sign ? CMP_LT : CMP_GT;
    end else if (mag_a == mag_b) begin
      w_cmp_flags = CMP_EQ;
    end else if ((mag_a < mag_b) ^ w_ua.sign) begin
      w_cmp_flags = CMP_LT;
    end
  end

  // Signed-magnitude add of the aligned mantissas; exact zero is +0
  always_comb begin
    w_add_sum  = {1'b0, r_mx} + {1'b0, r_my};
    w_add_sign = r_sx;
    if (r_sx != r_sy) begin
      if (r_mx >= r_my) begin
        w_add_sum  = {1'b0, r_mx} - {1'b0, r_my};
        w_add_sign = r_sx;
      end else begin
        w_add_sum  = {1'b0, r_my} - {1'b0, r_mx};
        w_add_sign = r_sy;
      end
    end
    if (w_add_sum == '0) begin
      w_add_sign = 1'b0;
    end
  end

  // Final packing of the normalised sum, with optional RNE increment
`ifdef FPU_RNE_EN
  logic        w_inc;
  logic [23:0] w_rnd;
  always_comb begin
    w_inc         = r_sum[2] & (r_sum[1] | r_sum[0] | r_sum[3]);
    w_rnd         = {1'b0, r_sum[25:3]} + 24'(w_inc);
    w_pack        = {r_rs, r_exp[7:0], w_rnd[22:0]};
    w_ovf         = 1'b0;
    w_round_again = 1'b0;
    if (r_sum == '0) begin
      w_pack = {r_rs, 31'd0};
    end else if (r_exp >= 10'd255) begin
      w_pack = {r_rs, EXP_MAX, 23'd0};
      w_ovf  = 1'b1;
    end else begin
      // fraction wrapped to zero: mantissa became 2.0, needs one more pass
      w_round_again = w_rnd[23];
    end
  end
`else
  always_comb begin
    w_pack        = {r_rs, r_exp[7:0], r_sum[25:3]};
    w_ovf         = 1'b0;
    w_round_again = 1'b0;
    if (r_sum == '0) begin
      w_pack = {r_rs, 31'd0};
    end else if (r_exp >= 10'd255) begin
      w_pack = {r_rs, EXP_MAX, 23'd0};
      w_ovf  = 1'b1;
    end
  end
`endif

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_op     <= 2'b00;
      r_sflag  <= 1'b0;
      r_ex     <= '0;
      r_diff   <= '0;
      r_mx     <= '0;
      r_my     <= '0;
      r_sx     <= 1'b0;
      r_sy     <= 1'b0;
      r_sum    <= '0;
      r_rs     <= 1'b0;
      r_exp    <= 10'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= 32'd0;
      FPUFlags <= 4'd0;
      FPUFlagW <= 2'b00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_sflag <= sflag;
            busy    <= 1'b1;
            r_state <= ST_UNPACK;
          end
        end

        ST_UNPACK: begin
          if (w_is_cmp) begin
            r_state <= ST_CMP;
          end else if (w_any_spec) begin
            r_state <= ST_SPECIAL;
          end else begin
            // larger-exponent operand becomes X; Y is the one to shift
            if (w_ua.exp >= w_ub.exp) begin
              r_ex   <= w_ua.exp;
              r_diff <= w_ua.exp - w_ub.exp;
              r_mx   <= {w_ua.mant, 3'b000};
              r_sx   <= w_ua.sign;
              r_my   <= {w_ub.mant, 3'b000};
              r_sy   <= w_sb_eff;
            end else begin
              r_ex   <= w_ub.exp;
              r_diff <= w_ub.exp - w_ua.exp;
              r_mx   <= {w_ub.mant, 3'b000};
              r_sx   <= w_sb_eff;
              r_my   <= {w_ua.mant, 3'b000};
              r_sy   <= w_ua.sign;
            end
            r_state <= ST_ALIGN;
          end
        end

        ST_CMP: begin
          result   <= 32'd0;
          FPUFlags <= w_cmp_flags;
          FPUFlagW <= 2'b11;
          done     <= 1'b1;
          r_state  <= ST_DONE;
        end

        ST_SPECIAL: begin
          result   <= w_spec_res;
          FPUFlags <= add_nzcv(w_spec_res, 1'b0);
          FPUFlagW <= r_sflag ? 2'b11 : 2'b00;
          done     <= 1'b1;
          r_state  <= ST_DONE;
        end

        ST_ALIGN: begin
          if (r_diff >= ALIGN_LIM) begin
            // too far apart: only a sticky bit survives
            r_my    <= WORK_W'(1);
            r_diff  <= '0;
            r_state <= ST_ADD;
          end else if (r_diff == '0) begin
            r_state <= ST_ADD;
          end else begin
            r_my   <= {1'b0, r_my[WORK_W-1:2], r_my[1] | r_my[0]};
            r_diff <= r_diff - EXP_W'(1);
          end
        end

        ST_ADD: begin
          r_sum   <= w_add_sum;
          r_rs    <= w_add_sign;
          r_exp   <= {2'b00, r_ex};
          r_state <= ST_NORM;
        end

        ST_NORM: begin
          if (r_sum == '0) begin
            r_state <= ST_ROUND;
          end else if (r_sum[SUM_W-1]) begin
            r_sum   <= {1'b0, r_sum[SUM_W-1:2], r_sum[1] | r_sum[0]};
            r_exp   <= r_exp + 10'd1;
            r_state <= ST_ROUND;
          end else if (r_sum[SUM_W-2]) begin
            r_state <= ST_ROUND;
          end else if (r_exp <= 10'd1) begin
            // would go denormal: flush to signed zero
            r_sum   <= '0;
            r_state <= ST_ROUND;
          end else begin
            r_sum <= {r_sum[SUM_W-2:0], 1'b0};
            r_exp <= r_exp - 10'd1;
          end
        end

        ST_ROUND: begin
          if (w_round_again) begin
            r_sum <= SUM_W'(28'h400_0000);
            r_exp <= r_exp + 10'd1;
          end else begin
            result   <= w_pack;
            FPUFlags <= add_nzcv(w_pack, w_ovf);
            FPUFlagW <= r_sflag ? 2'b11 : 2'b00;
            done     <= 1'b1;
            r_state  <= ST_DONE;
          end
        end

        ST_DONE: begin
          done     <= 1'b0;
          FPUFlagW <= 2'b00;
          busy     <= 1'b0;
          r_state  <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_flaggen.sv
// tb_fpu_flaggen: directed bench for fpu_flaggen. Expected result/flags are
// queued at launch and popped when done pulses.
module tb_fpu_flaggen;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic        sflag;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [3:0]  FPUFlags;
  logic [1:0]  FPUFlagW;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    logic [1:0]  w;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

`ifdef FPU_RNE_EN
  localparam logic [31:0] TINY_SUM = 32'h3F80_0001;
`else
  localparam logic [31:0] TINY_SUM = 32'h3F80_0000;
`endif

  fpu_flaggen dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .sflag    (sflag),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .FPUFlags (FPUFlags),
    .FPUFlagW (FPUFlagW)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Launch one op, wait (bounded) for done, compare against the queued entry.
  // poke pulses start while busy and on the done cycle; both must be ignored.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic s, input logic [31:0] er,
                       input logic [3:0] ef, input logic [1:0] ew, input int lat,
                       input bit poke);
    exp_t e;
    int   n;
    int   extra;
    sb_q.push_back('{er, ef, ew});
    start = 1'b1; op = o; a = x; b = y; sflag = s;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom_range(3)); sflag = 1'($urandom_range(1));
    n = 1;
    check({tag, ".busy_rise"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && n < 100) begin
      start = poke && (n == 2);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check({tag, ".done_seen"}, 32'(done), 32'd1);
    if (lat != 0) check({tag, ".latency"}, 32'(n), 32'(lat));
    e = sb_q.pop_front();
    check({tag, ".result"}, result, e.res);
    check({tag, ".flags"}, 32'(FPUFlags), 32'(e.flags));
    check({tag, ".flagw"}, 32'(FPUFlagW), 32'(e.w));
    if (poke) begin
      start = 1'b1; op = OP_CMP;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".done_fall"}, 32'(done), 32'd0);
    check({tag, ".flagw_clr"}, 32'(FPUFlagW), 32'd0);
    check({tag, ".result_hold"}, result, e.res);
    check({tag, ".busy_fall"}, 32'(busy), 32'd0);
    if (poke) begin
      extra = 0;
      repeat (8) begin
        @(posedge clk); #1;
        if (done === 1'b1) extra++;
      end
      check({tag, ".no_extra_done"}, 32'(extra), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 2'b00; sflag = 1'b0; a = 32'd0; b = 32'd0;
    #12;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.result", result, 32'd0);
    check("rst.flags", 32'(FPUFlags), 32'd0);
    check("rst.flagw", 32'(FPUFlagW), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    do_op("cmp_lt",    OP_CMP, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'd0,         4'b1000, 2'b11, 3, 1'b0);
    do_op("add_1p1",   OP_ADD, 32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 4'b0000, 2'b11, 0, 1'b0);
    do_op("add_ns",    OP_ADD, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 4'b0000, 2'b00, 0, 1'b0);
    do_op("sub_zero",  OP_SUB, 32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 4'b0100, 2'b11, 0, 1'b0);
    do_op("add_ovf",   OP_ADD, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b1, 32'h7F80_0000, 4'b0001, 2'b11, 0, 1'b0);
    do_op("cmp_nan",   OP_CMP, 32'h7FC0_0000, 32'h3F80_0000, 1'b1, 32'd0,         4'b0011, 2'b11, 3, 1'b0);
    do_op("add_tiny",  OP_ADD, 32'h3F80_0000, 32'h33C0_0000, 1'b1, TINY_SUM,      4'b0000, 2'b11, 0, 1'b0);
    do_op("cmp_zeros", OP_CMP, 32'h0000_0000, 32'h8000_0000, 1'b0, 32'd0,         4'b0110, 2'b11, 3, 1'b0);
    do_op("cmp_gt",    OP_CMP, 32'h4000_0000, 32'h3F80_0000, 1'b0, 32'd0,         4'b0010, 2'b11, 3, 1'b0);
    do_op("sub_neg",   OP_SUB, 32'h3F80_0000, 32'h4000_0000, 1'b1, 32'hBF80_0000, 4'b1000, 2'b11, 0, 1'b0);
    do_op("inf_minf",  OP_ADD, 32'h7F80_0000, 32'hFF80_0000, 1'b1, 32'h7FC0_0000, 4'b0001, 2'b11, 3, 1'b0);
    do_op("cmp_rsv",   OP_RSV, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'd0,         4'b0110, 2'b11, 3, 1'b0);
    do_op("add_dnrm",  OP_ADD, 32'h3F80_0000, 32'h0000_0001, 1'b0, 32'h3F80_0000, 4'b0000, 2'b00, 3, 1'b0);
    do_op("poke",      OP_ADD, 32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 4'b0000, 2'b11, 0, 1'b1);

    // Abort during the alignment shifts; reset clears outputs at once
    start = 1'b1; op = OP_ADD; a = 32'h3F80_0000; b = 32'h3580_0000; sflag = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort.busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.flagw", 32'(FPUFlagW), 32'd0);
    check("abort.result", result, 32'd0);
    check("abort.flags", 32'(FPUFlags), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    do_op("after_abort", OP_ADD, 32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 4'b0000, 2'b11, 0, 1'b0);

    check("sb.empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
